// File: rtl/jpeg_dma_wr_pkg.sv
// jpeg_dma_wr_pkg
// Shared definitions for the JPEG write-back DMA.
//   JPEG_BLK_WORDS : 32-bit words in one quantized 8x8 coefficient block
//                    (64 coefficients, two per word).
//   dma_wr_state_t : FSM state encoding, also the encoding seen on the
//                    debug state output.
package jpeg_dma_wr_pkg;

  localparam int JPEG_BLK_WORDS = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } dma_wr_state_t;

endpackage

// File: rtl/jpeg_dma_wr_if.sv
// jpeg_dma_wr_if
// Wishbone classic master bus used by the write-back DMA.
//   adr  : byte address           dat : write data
//   sel  : byte selects           we  : write enable
//   cyc  : bus cycle              stb : strobe
//   ack  : acknowledge (slave)    err : bus error (slave)
// Handshake: a transfer is offered while stb is high; the master holds adr,
// dat, sel and we stable until the slave raises ack or err. The word is
// consumed on the clock edge where stb and (ack or err) are both high; ack or
// err in the same cycle stb rises is legal. ack/err while stb is low mean
// nothing and are ignored.
interface jpeg_dma_wr_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  modport master (output adr, dat, sel, we, cyc, stb, input ack, err);
  modport slave  (input adr, dat, sel, we, cyc, stb, output ack, err);
endinterface

// File: rtl/jpeg_dma_wr.sv
// jpeg_dma_wr
// Write-back DMA: copies one coefficient block (NWORDS 32-bit words) from
// the output block RAM to system memory as single Wishbone write cycles.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   start_i         : one-cycle request, accepted only in IDLE
//   dst_base_i      : destination byte address, bits [1:0] ignored
//   busy_o          : transfer in progress
//   done_o          : one-cycle pulse after the last word is acked
//   err_o           : sticky bus error, cleared by the next accepted start
//   bram_addr_o     : block RAM word address
//   bram_dat_i      : block RAM data, valid one cycle after the address
//   wbm             : Wishbone master bus
//   dbg_state_o     : current FSM state (dma_wr_state_t encoding)
module jpeg_dma_wr
  import jpeg_dma_wr_pkg::*;
#(
  parameter int NWORDS = JPEG_BLK_WORDS,
  parameter int AW     = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          dst_base_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [AW-1:0]        bram_addr_o,
  input  logic [31:0]          bram_dat_i,
  jpeg_dma_wr_if.master        wbm,
  output logic [2:0]           dbg_state_o
);

  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_FETCH = FETCH;
  localparam logic [2:0] S_WRITE = WRITE;
  localparam logic [2:0] S_DONE  = DONE;
  localparam logic [2:0] S_ERR   = ERR;

  logic [2:0]    state_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   base_q;
  logic [31:0]   data_q;
  logic          fetch_ph_q;  // 0: address cycle, 1: RAM data valid
  logic          err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      base_q     <= '0;
      data_q     <= '0;
      fetch_ph_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            base_q     <= dst_base_i & 32'hFFFF_FFFC;
            idx_q      <= '0;
            err_q      <= 1'b0;
            fetch_ph_q <= 1'b0;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          // The RAM has one cycle of read latency, so FETCH spans two
          // cycles: present the address, then capture the data.
          if (!fetch_ph_q) begin
            fetch_ph_q <= 1'b1;
          end else begin
            fetch_ph_q <= 1'b0;
            data_q     <= bram_dat_i;
            state_q    <= S_WRITE;
          end
        end
        S_WRITE: begin
          // err wins over a simultaneous ack.
          if (wbm.err) begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else if (wbm.ack) begin
            if (idx_q == LAST_IDX) begin
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state so that an asynchronous reset
  // drops cyc/stb/busy immediately.
  always_comb begin
    busy_o      = 1'b0;
    done_o      = 1'b0;
    bram_addr_o = '0;
    wbm.adr     = '0;
    wbm.dat     = '0;
    wbm.sel     = 4'h0;
    wbm.we      = 1'b0;
    wbm.cyc     = 1'b0;
    wbm.stb     = 1'b0;
    case (state_q)
      S_FETCH: begin
        busy_o      = 1'b1;
        bram_addr_o = AW'(idx_q);
        // Bus is not yet claimed while the very first word is fetched;
        // afterwards cyc stays high across the whole block.
        wbm.cyc     = (idx_q != '0);
      end
      S_WRITE: begin
        busy_o  = 1'b1;
        wbm.cyc = 1'b1;
        wbm.stb = 1'b1;
        wbm.we  = 1'b1;
        wbm.sel = 4'hF;
        wbm.adr = base_q + (32'(idx_q) << 2);
        wbm.dat = data_q;
      end
      S_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      S_ERR: begin
        busy_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_jpeg_dma_wr.sv
// tb_jpeg_dma_wr
// Self-checking bench for jpeg_dma_wr: block RAM model, Wishbone slave with
// configurable wait states and injected errors, and an address/data
// scoreboard built from the block's transfer rules.
module tb_jpeg_dma_wr;

  localparam int NWORDS = 32;
  localparam int AW     = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start;
  logic [31:0]   dst_base;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_dat;
  logic [2:0]    dbg_state;

  jpeg_dma_wr_if wb();

  jpeg_dma_wr #(.NWORDS(NWORDS), .AW(AW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .dst_base_i  (dst_base),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .bram_addr_o (bram_addr),
    .bram_dat_i  (bram_dat),
    .wbm         (wb),
    .dbg_state_o (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];          // {address, data} per expected write
  logic [31:0] mem [NWORDS];
  logic [31:0] got_adr [NWORDS];

  int  neg_n = 0;
  int  start_neg, done_neg, err_neg;
  int  done_cnt, acked, cyc_gaps;
  int  wcnt = 0;
  int  cur_ws = 0;
  int  ws_fixed = 0;
  int  err_word = -1;
  bit  ws_rand = 1'b0;
  bit  spur_en = 1'b0;
  bit  blk_active = 1'b0;
  bit  err_fired;
  logic [31:0] hold_adr, hold_dat;
  logic [3:0]  hold_sel;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- block RAM model: one cycle read latency ----------------
  always @(posedge clk)
    bram_dat <= (bram_addr < AW'(NWORDS)) ? mem[bram_addr[4:0]] : 32'hDEAD_BEEF;

  // ---------------- slave, monitor and scoreboard ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    neg_n++;
    if (!rst_n) begin
      wb.ack     = 1'b0;
      wb.err     = 1'b0;
      blk_active = 1'b0;
      wcnt       = 0;
    end else begin
      wb.ack = 1'b0;
      wb.err = 1'b0;
      if (done) begin
        done_cnt++;
        done_neg = neg_n;
      end
      if (blk_active && !wb.cyc) cyc_gaps++;
      if (wb.stb) begin
        blk_active = 1'b1;
        if (wcnt == 0) begin
          hold_adr = wb.adr;
          hold_dat = wb.dat;
          hold_sel = wb.sel;
          cur_ws   = ws_rand ? int'($urandom_range(0, 3)) : ws_fixed;
        end else begin
          check_eq("hold_adr", wb.adr, hold_adr);
          check_eq("hold_dat", wb.dat, hold_dat);
          check_eq("hold_sel", 32'(wb.sel), 32'(hold_sel));
        end
        if (wcnt == cur_ws) begin
          wb.ack = 1'b1;
          wcnt   = 0;
          if (exp_q.size() == 0) begin
            check_eq("extra_write", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check_eq("wr_adr", wb.adr, e[63:32]);
            check_eq("wr_dat", wb.dat, e[31:0]);
            check_eq("wr_sel", 32'(wb.sel), 32'hF);
            check_eq("wr_we", 32'(wb.we), 32'd1);
          end
          if (acked < NWORDS) got_adr[acked] = wb.adr;
          if (acked == err_word) begin
            wb.err     = 1'b1;
            err_fired  = 1'b1;
            err_neg    = neg_n;
            blk_active = 1'b0;
          end
          acked++;
          if (acked == NWORDS) blk_active = 1'b0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
        if (spur_en && $urandom_range(0, 3) == 0) begin
          wb.ack = 1'b1;
          wb.err = 1'(($urandom_range(0, 1)));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_mem_pattern();
    for (int i = 0; i < NWORDS; i++) mem[i] = 32'hA5A5_0000 + 32'(i);
  endtask

  task automatic fill_mem_random();
    for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
  endtask

  // Reference model: word i lands at the aligned base plus 4*i, mod 2^32.
  task automatic begin_xfer(input logic [31:0] base);
    logic [31:0] b;
    @(negedge clk); #1;
    b = {base[31:2], 2'b00};
    exp_q.delete();
    for (int i = 0; i < NWORDS; i++)
      exp_q.push_back({b + 32'(4 * i), mem[i]});
    acked     = 0;
    done_cnt  = 0;
    cyc_gaps  = 0;
    err_fired = 1'b0;
    dst_base  = base;
    start     = 1'b1;
    start_neg = neg_n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (busy && n < 3000);
    check_eq("xfer_timeout", 32'(n >= 3000), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_acked(input int k);
    int n = 0;
    while (acked < k && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("ack_wait_timeout", 32'(n >= 1000), 32'd0);
  endtask

  // exp_lat < 0 skips the latency check (wait-state runs).
  task automatic finish_xfer(input int exp_lat);
    check_eq("done_cnt", 32'(done_cnt), 32'd1);
    check_eq("words_acked", 32'(acked), 32'(NWORDS));
    check_eq("exp_left", 32'(exp_q.size()), 32'd0);
    check_eq("cyc_gaps", 32'(cyc_gaps), 32'd0);
    check_eq("err_clear", 32'(err), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    if (exp_lat >= 0) check_eq("done_latency", 32'(done_neg - start_neg), 32'(exp_lat));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    start    = 1'b0;
    dst_base = 32'h0;
    fill_mem_pattern();

    // Reset state
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_bram_addr", 32'(bram_addr), 32'd0);
    check_eq("rst_adr", wb.adr, 32'd0);
    check_eq("rst_dat", wb.dat, 32'd0);
    check_eq("rst_sel", 32'(wb.sel), 32'd0);
    check_eq("rst_we", 32'(wb.we), 32'd0);
    check_eq("rst_cyc", 32'(wb.cyc), 32'd0);
    check_eq("rst_stb", 32'(wb.stb), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // 1: zero-wait slave; done is the 98th cycle counting the start cycle
    // as the first, i.e. 97 cycles after it.
    fill_mem_pattern();
    begin_xfer(32'h0010_0000);
    wait_idle();
    finish_xfer(97);
    check_eq("t1_last_adr", got_adr[NWORDS-1], 32'h0010_007C);

    // 2: three wait states per word
    ws_fixed = 3;
    fill_mem_random();
    begin_xfer(32'h0010_0000);
    wait_idle();
    finish_xfer(-1);
    ws_fixed = 0;

    // 3: start re-asserted mid-block is ignored
    fill_mem_pattern();
    begin_xfer(32'h0010_0000);
    wait_acked(10);
    dst_base = 32'h2000_0000;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    wait_idle();
    finish_xfer(97);
    check_eq("t3_last_adr_hi", 32'(got_adr[NWORDS-1] >> 8), 32'h0000_1000);
    repeat (5) @(negedge clk);
    check_eq("t3_no_requeue", 32'(busy), 32'd0);

    // 4: bus error with ack on word 5
    err_word = 5;
    fill_mem_random();
    begin_xfer(32'h0040_0100);
    begin
      int n = 0;
      while (!err_fired && n < 500) begin
        @(negedge clk); #1;
        n++;
      end
      check_eq("err_wait_timeout", 32'(n >= 500), 32'd0);
    end
    @(negedge clk); #1;
    check_eq("t4_cyc_drop", 32'(wb.cyc), 32'd0);
    check_eq("t4_err_set", 32'(err), 32'd1);
    check_eq("t4_busy_err", 32'(busy), 32'd1);
    @(negedge clk); #1;
    check_eq("t4_busy_off", 32'(busy), 32'd0);
    check_eq("t4_err_sticky", 32'(err), 32'd1);
    check_eq("t4_no_done", 32'(done_cnt), 32'd0);
    check_eq("t4_words_left", 32'(exp_q.size()), 32'(NWORDS - 6));
    err_word = -1;
    repeat (3) @(negedge clk);
    check_eq("t4_err_hold", 32'(err), 32'd1);
    fill_mem_pattern();
    begin_xfer(32'h0040_0100);
    check_eq("t4_err_cleared", 32'(err), 32'd0);
    wait_idle();
    finish_xfer(97);

    // 5: unaligned base near the top of the address space wraps
    fill_mem_random();
    begin_xfer(32'hFFFF_FFC3);
    wait_idle();
    finish_xfer(97);
    check_eq("t5_first_adr", got_adr[0], 32'hFFFF_FFC0);
    check_eq("t5_adr15", got_adr[15], 32'hFFFF_FFFC);
    check_eq("t5_adr16", got_adr[16], 32'h0000_0000);

    // 6: asynchronous reset mid-block
    fill_mem_random();
    begin_xfer(32'h0010_0000);
    wait_acked(20);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t6_cyc_async", 32'(wb.cyc), 32'd0);
    check_eq("t6_stb_async", 32'(wb.stb), 32'd0);
    check_eq("t6_busy_async", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("t6_no_done", 32'(done_cnt), 32'd0);
    check_eq("t6_state_idle", 32'(dbg_state), 32'd0);
    #2 rst_n = 1'b1;
    fill_mem_pattern();
    begin_xfer(32'h0010_0000);
    wait_idle();
    finish_xfer(97);
    check_eq("t6_first_adr", got_adr[0], 32'h0010_0000);

    // Random: bases, data, wait states and spurious ack/err while stb is low
    ws_rand = 1'b1;
    spur_en = 1'b1;
    for (int t = 0; t < 4; t++) begin
      fill_mem_random();
      begin_xfer($urandom);
      wait_idle();
      finish_xfer(-1);
    end
    ws_rand = 1'b0;
    spur_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
